// File: rtl/ring_code_checker.sv
// ring_code_checker: validates a rotating one-hot ring code, decodes its index,
// tracks acquire/lock and counts sequence errors seen while locked.
module ring_code_checker #(
    parameter int WIDTH = 4,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_CNT_W = 8,
    localparam int IDXW = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     ring_in,
    input  logic                 err_clr,
    output logic [IDXW-1:0]      index,
    output logic                 index_valid,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 wrap_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);
    typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;
    state_t state, state_n;
    logic [IDXW-1:0] prev, prev_n, idx, expect_idx;
    logic [3:0] run, run_n;
    logic onehot, seq_ok, err, wrap;
    always_comb begin
        onehot = |ring_in && ~|(ring_in & (ring_in - WIDTH'(1)));
        idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (ring_in[i]) idx = IDXW'(i);
        expect_idx = (prev == IDXW'(WIDTH - 1)) ? '0 : prev + IDXW'(1);
        seq_ok = onehot && idx == expect_idx;
    end
    always_comb begin
        state_n = state;
        prev_n = prev;
        run_n = run;
        wrap = 1'b0;
        err = in_valid && state == LOCKED && !seq_ok;
        if (in_valid) begin
            if (!onehot) begin
                state_n = HUNT;
                run_n = '0;
            end else if (state == HUNT || !seq_ok) begin
                state_n = ACQ;
                prev_n = idx;
                run_n = 4'd1;
            end else if (state == ACQ) begin
                prev_n = idx;
                run_n = run + 4'd1;
                state_n = (run_n == 4'(LOCK_COUNT)) ? LOCKED : ACQ;
            end else begin
                prev_n = idx;
                wrap = idx == '0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
            prev <= '0;
            run <= '0;
            index <= '0;
            index_valid <= 1'b0;
            locked <= 1'b0;
            err_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state <= state_n;
            prev <= prev_n;
            run <= run_n;
            index_valid <= in_valid && onehot;
            if (in_valid && onehot) index <= idx;
            locked <= state_n == LOCKED;
            err_pulse <= err;
            wrap_pulse <= wrap;
            // clear wins over the increment but still records a coincident error
            err_count <= err_clr ? ERR_CNT_W'(err) :
                         (err && ~&err_count) ? err_count + ERR_CNT_W'(1) : err_count;
        end
    end
endmodule

// File: tb/tb_ring_code_checker.sv
// tb_ring_code_checker: directed vector table plus a rotation/wrap sequence;
// a second instance with a 2-bit error counter exercises saturation.
module tb_ring_code_checker;
    logic clk = 1'b0;
    logic rst, in_valid, err_clr;
    logic [3:0] ring_in;
    logic [1:0] index, index2;
    logic index_valid, locked, err_pulse, wrap_pulse;
    logic index_valid2, locked2, err_pulse2, wrap_pulse2;
    logic [7:0] err_count;
    logic [1:0] err_count2;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    ring_code_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ring_in(ring_in), .err_clr(err_clr),
        .index(index), .index_valid(index_valid), .locked(locked), .err_pulse(err_pulse),
        .wrap_pulse(wrap_pulse), .err_count(err_count)
    );
    ring_code_checker #(.ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ring_in(ring_in), .err_clr(err_clr),
        .index(index2), .index_valid(index_valid2), .locked(locked2), .err_pulse(err_pulse2),
        .wrap_pulse(wrap_pulse2), .err_count(err_count2)
    );
    typedef struct {
        logic rst, v;
        logic [3:0] r;
        logic clr;
        logic [1:0] idx;
        logic iv, lk, ep, wp;
        logic [7:0] ec;
        logic [1:0] ec2;
    } vec_t;
    vec_t vecs[39];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask
    initial begin
        int wraps;
        rst = 1'b1; in_valid = 1'b0; err_clr = 1'b0; ring_in = '0;
        vecs = '{
            '{1,1,4'b0001,0, 0,0,0,0,0, 0,0},
            '{0,1,4'b0001,0, 0,1,0,0,0, 0,0},
            '{0,1,4'b0010,0, 1,1,0,0,0, 0,0},
            '{0,1,4'b0100,0, 2,1,1,0,0, 0,0},
            '{0,1,4'b1000,0, 3,1,1,0,0, 0,0},
            '{0,1,4'b0001,0, 0,1,1,0,1, 0,0},
            '{0,1,4'b0110,0, 0,0,0,1,0, 1,1},
            '{0,1,4'b1000,0, 3,1,0,0,0, 1,1},
            '{0,1,4'b0001,0, 0,1,0,0,0, 1,1},
            '{0,1,4'b0010,0, 1,1,1,0,0, 1,1},
            '{0,1,4'b0100,0, 2,1,1,0,0, 1,1},
            '{0,1,4'b1000,0, 3,1,1,0,0, 1,1},
            '{0,1,4'b0001,0, 0,1,1,0,1, 1,1},
            '{0,1,4'b0100,0, 2,1,0,1,0, 2,2},
            '{0,1,4'b1000,0, 3,1,0,0,0, 2,2},
            '{0,1,4'b0001,0, 0,1,1,0,0, 2,2},
            '{0,1,4'b0010,0, 1,1,1,0,0, 2,2},
            '{0,1,4'b0010,0, 1,1,0,1,0, 3,3},
            '{0,1,4'b0100,0, 2,1,0,0,0, 3,3},
            '{0,1,4'b1000,0, 3,1,1,0,0, 3,3},
            '{0,1,4'b0001,0, 0,1,1,0,1, 3,3},
            '{0,0,4'b1111,0, 0,0,1,0,0, 3,3},
            '{0,0,4'b1111,0, 0,0,1,0,0, 3,3},
            '{0,1,4'b0010,0, 1,1,1,0,0, 3,3},
            '{0,1,4'b0000,0, 1,0,0,1,0, 4,3},
            '{0,1,4'b0100,0, 2,1,0,0,0, 4,3},
            '{0,1,4'b1000,0, 3,1,0,0,0, 4,3},
            '{0,1,4'b0001,0, 0,1,1,0,0, 4,3},
            '{0,1,4'b0001,0, 0,1,0,1,0, 5,3},
            '{0,0,4'b0000,1, 0,0,0,0,0, 0,0},
            '{0,1,4'b0010,0, 1,1,0,0,0, 0,0},
            '{0,1,4'b0100,0, 2,1,1,0,0, 0,0},
            '{0,1,4'b0100,1, 2,1,0,1,0, 1,1},
            '{0,1,4'b1000,0, 3,1,0,0,0, 1,1},
            '{0,1,4'b0001,0, 0,1,1,0,0, 1,1},
            '{1,1,4'b0010,0, 0,0,0,0,0, 0,0},
            '{0,1,4'b0100,0, 2,1,0,0,0, 0,0},
            '{0,1,4'b1000,0, 3,1,0,0,0, 0,0},
            '{0,1,4'b0001,0, 0,1,1,0,0, 0,0}
        };
        cycle();
        for (int i = 0; i < 39; i++) begin
            rst = vecs[i].rst; in_valid = vecs[i].v; ring_in = vecs[i].r; err_clr = vecs[i].clr;
            cycle();
            chk($sformatf("row%0d index", i), 32'(index), 32'(vecs[i].idx));
            chk($sformatf("row%0d index_valid", i), 32'(index_valid), 32'(vecs[i].iv));
            chk($sformatf("row%0d locked", i), 32'(locked), 32'(vecs[i].lk));
            chk($sformatf("row%0d err_pulse", i), 32'(err_pulse), 32'(vecs[i].ep));
            chk($sformatf("row%0d wrap_pulse", i), 32'(wrap_pulse), 32'(vecs[i].wp));
            chk($sformatf("row%0d err_count", i), 32'(err_count), 32'(vecs[i].ec));
            chk($sformatf("row%0d err_count_w2", i), 32'(err_count2), 32'(vecs[i].ec2));
        end
        wraps = 0;
        rst = 1'b0; err_clr = 1'b0; in_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            ring_in = 4'b0001 << (k % 4);
            cycle();
            wraps += int'(wrap_pulse);
            chk($sformatf("rot%0d locked", k), 32'(locked), 32'd1);
            chk($sformatf("rot%0d index", k), 32'(index), 32'(k % 4));
            chk($sformatf("rot%0d wrap_pulse", k), 32'(wrap_pulse), 32'(k % 4 == 0));
        end
        chk("rot wrap total", 32'(wraps), 32'd3);
        chk("rot err_count", 32'(err_count), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
